// File: rtl/alarm_switch_debounce.sv
// alarm_switch_debounce
// ---------------------------------------------------------------------------
// Conditions the alarm slide switches before they reach the PIO in_port.
// Each raw pin is brought into the clk domain through a two-flop
// synchronizer. It is then debounced on its own: a new level is accepted
// only after it has persisted for DEBOUNCE_CYCLES consecutive cycles.
// Registered one-cycle rise/fall pulses are produced on every accepted change.
//
// Ports
//   clk       : system clock, the only clock
//   reset     : synchronous, active-high reset
//   sw_raw    : raw switch pins (asynchronous to clk, may bounce)
//   sw_clean  : debounced, registered switch levels (to PIO in_port)
//   sw_rise   : one-cycle pulse per bit when sw_clean[i] goes 0->1
//   sw_fall   : one-cycle pulse per bit when sw_clean[i] goes 1->0
//
// DEBOUNCE_CYCLES must be >= 2. The counter width is derived from it.
// ---------------------------------------------------------------------------
module alarm_switch_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer stages: plain flop-to-flop, nothing in between.
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Per-bit debounce state.
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // Next-state values computed combinationally from the registered state.
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_clean_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;

    // -----------------------------------------------------------------------
    // Debounce next-state. A cycle where the synchronized level matches the
    // accepted level restarts qualification, so a single glitch back to the
    // old level throws away all progress. The counter saturates at CNT_MAX
    // only when the level is accepted. It returns to zero on that same edge,
    // so it can never wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        w_clean_nxt = r_clean;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end

        for (int i = 0; i < WIDTH; i++) begin
            if (r_s2[i] == r_clean[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_cnt_nxt[i]   = '0;
                w_clean_nxt[i] = r_s2[i];
                // The pulse is loaded on the same edge as the level, so it
                // lines up with the sw_clean change.
                w_rise_nxt[i]  = r_s2[i];
                w_fall_nxt[i]  = ~r_s2[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers. Reset clears everything, including the synchronizer.
    // A switch that is already held high therefore re-qualifies as a fresh
    // 0->1 change after release.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1    <= sw_raw;
            r_s2    <= r_s1;
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Every output is a flop Q; no input reaches an output combinationally.
    assign sw_clean = r_clean;
    assign sw_rise  = r_rise;
    assign sw_fall  = r_fall;

endmodule

// File: tb/tb_alarm_switch_debounce.sv
// Directed bench for alarm_switch_debounce with WIDTH=2, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge. The next rising edge is
// therefore "edge 1" for the new value, and sw_clean is expected to update on
// edge D+2 = 6. Each expected {clean, rise, fall} vector is queued per edge,
// then popped and compared one edge at a time.
module tb_alarm_switch_debounce;

  localparam int W = 2;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;

  always #5 clk = ~clk;

  alarm_switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [3*W-1:0] exp_q[$];

  function automatic logic [3*W-1:0] pk(input logic [W-1:0] c,
                                        input logic [W-1:0] r,
                                        input logic [W-1:0] f);
    return {c, r, f};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3*W-1:0] expv);
    logic [3*W-1:0] obs;
    obs = {sw_clean, sw_rise, sw_fall};
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: clean/rise/fall observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic expect_n(input int n, input logic [3*W-1:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  // Advance one edge per queued entry and compare against it.
  task automatic run_q(input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      tick();
      k++;
      check($sformatf("%s edge%0d", tag, k), exp_q.pop_front());
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset with switches held high: everything stays zero during reset.
    reset  = 1'b1;
    sw_raw = 2'b11;
    expect_n(3, pk(2'b00, 2'b00, 2'b00));
    run_q("reset_hold");
    // After release the held-high switches qualify on edge 6 as a rise.
    reset = 1'b0;
    expect_n(5, pk(2'b00, 2'b00, 2'b00));
    expect_n(1, pk(2'b11, 2'b11, 2'b00));
    expect_n(2, pk(2'b11, 2'b00, 2'b00));
    run_q("reset_release");

    // Clean step on bit 0 starting from 00.
    reset  = 1'b1;
    sw_raw = 2'b00;
    expect_n(1, pk(2'b00, 2'b00, 2'b00));
    run_q("step_reset");
    reset  = 1'b0;
    sw_raw = 2'b01;
    expect_n(5, pk(2'b00, 2'b00, 2'b00));
    expect_n(1, pk(2'b01, 2'b01, 2'b00));
    expect_n(2, pk(2'b01, 2'b00, 2'b00));
    run_q("clean_step");

    // Bounce rejection on bit 0: toggling 1,0,1,0, then a steady 1.
    reset  = 1'b1;
    sw_raw = 2'b00;
    expect_n(1, pk(2'b00, 2'b00, 2'b00));
    run_q("bounce_reset");
    reset = 1'b0;
    sw_raw = 2'b01; expect_n(1, pk(2'b00, 2'b00, 2'b00)); run_q("bounce_t1");
    sw_raw = 2'b00; expect_n(1, pk(2'b00, 2'b00, 2'b00)); run_q("bounce_t2");
    sw_raw = 2'b01; expect_n(1, pk(2'b00, 2'b00, 2'b00)); run_q("bounce_t3");
    sw_raw = 2'b00; expect_n(1, pk(2'b00, 2'b00, 2'b00)); run_q("bounce_t4");
    sw_raw = 2'b01;
    expect_n(5, pk(2'b00, 2'b00, 2'b00));
    expect_n(1, pk(2'b01, 2'b01, 2'b00));
    expect_n(2, pk(2'b01, 2'b00, 2'b00));
    run_q("bounce_settle");

    // Bring bit 1 up so that both bits are set.
    sw_raw = 2'b11;
    expect_n(5, pk(2'b01, 2'b00, 2'b00));
    expect_n(1, pk(2'b11, 2'b10, 2'b00));
    expect_n(1, pk(2'b11, 2'b00, 2'b00));
    run_q("bit1_rise");

    // Fall and independence: bit 0 drops first, then bit 1 six edges later.
    sw_raw = 2'b10;
    expect_n(5, pk(2'b11, 2'b00, 2'b00));
    expect_n(1, pk(2'b10, 2'b00, 2'b01));
    run_q("fall_bit0");
    sw_raw = 2'b00;
    expect_n(5, pk(2'b10, 2'b00, 2'b00));
    expect_n(1, pk(2'b00, 2'b00, 2'b10));
    expect_n(2, pk(2'b00, 2'b00, 2'b00));
    run_q("fall_bit1");

    // Reset in the middle of a count: progress is discarded, and the rise
    // comes D+2 edges after release.
    sw_raw = 2'b01;
    expect_n(3, pk(2'b00, 2'b00, 2'b00));
    run_q("midcnt_pre");
    reset = 1'b1;
    expect_n(1, pk(2'b00, 2'b00, 2'b00));
    run_q("midcnt_reset");
    reset = 1'b0;
    expect_n(5, pk(2'b00, 2'b00, 2'b00));
    expect_n(1, pk(2'b01, 2'b01, 2'b00));
    expect_n(2, pk(2'b01, 2'b00, 2'b00));
    run_q("midcnt_post");

    // Reset on the edge where a fall pulse would have appeared: no pulse,
    // and with the switch low nothing qualifies afterwards.
    sw_raw = 2'b00;
    expect_n(5, pk(2'b01, 2'b00, 2'b00));
    run_q("midpulse_pre");
    reset = 1'b1;
    expect_n(1, pk(2'b00, 2'b00, 2'b00));
    run_q("midpulse_reset");
    reset = 1'b0;
    expect_n(8, pk(2'b00, 2'b00, 2'b00));
    run_q("midpulse_post");

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
